// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared integer ALU: two valid/ready
// requesters, operands registered for one execute cycle, result held until consumed.
module alu_arbiter #(
    parameter int D_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*D_WIDTH-1:0]   req_op1,
    input  logic [2*D_WIDTH-1:0]   req_op2,
    input  logic [7:0]             req_aluctrl,
    input  logic [5:0]             req_funct3,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [D_WIDTH-1:0]     rsp_aluout,
    output logic                   rsp_eq,
    output logic [D_WIDTH-1:0]     alu_aluop1,
    output logic [D_WIDTH-1:0]     alu_aluop2,
    output logic [3:0]             alu_aluctrl,
    output logic [2:0]             alu_funct3,
    input  logic [D_WIDTH-1:0]     alu_aluout,
    input  logic                   alu_eq
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state;
    logic                 pri;
    logic                 owner;
    logic                 gnt;
    logic [D_WIDTH-1:0]   op1_sel;
    logic [D_WIDTH-1:0]   op2_sel;
    logic [3:0]           ctrl_sel;
    logic [2:0]           f3_sel;

    // Contention goes to pri; otherwise the lone valid requester wins with no bubble.
    always_comb begin
        gnt      = (&req_valid) ? pri : req_valid[1];
        op1_sel  = gnt ? req_op1[2*D_WIDTH-1:D_WIDTH] : req_op1[D_WIDTH-1:0];
        op2_sel  = gnt ? req_op2[2*D_WIDTH-1:D_WIDTH] : req_op2[D_WIDTH-1:0];
        ctrl_sel = gnt ? req_aluctrl[7:4] : req_aluctrl[3:0];
        f3_sel   = gnt ? req_funct3[5:3]  : req_funct3[2:0];
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && |req_valid)
            req_ready = gnt ? 2'b10 : 2'b01;
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (state == RESP)
            rsp_valid = owner ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pri         <= 1'b0;
            owner       <= 1'b0;
            rsp_aluout  <= '0;
            rsp_eq      <= 1'b0;
            alu_aluop1  <= '0;
            alu_aluop2  <= '0;
            alu_aluctrl <= '0;
            alu_funct3  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        alu_aluop1  <= op1_sel;
                        alu_aluop2  <= op2_sel;
                        alu_aluctrl <= ctrl_sel;
                        alu_funct3  <= f3_sel;
                        owner       <= gnt;
                        pri         <= ~gnt;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_aluout <= alu_aluout;
                    rsp_eq     <= alu_eq;
                    state      <= RESP;
                end
                RESP: begin
                    // Only the owner's consume bit ends the response.
                    if (rsp_ready[owner])
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU on the ALU port, scoreboard of
// expected responses filled on accept and drained on the response handshake.
module tb_alu_arbiter;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_op1, req_op2;
    logic [7:0]      req_aluctrl;
    logic [5:0]      req_funct3;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [DW-1:0]   rsp_aluout;
    logic            rsp_eq;
    logic [DW-1:0]   alu_aluop1, alu_aluop2;
    logic [3:0]      alu_aluctrl;
    logic [2:0]      alu_funct3;
    logic [DW-1:0]   alu_aluout;
    logic            alu_eq;

    always #5 clk = ~clk;

    alu_arbiter #(.D_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2),
        .req_aluctrl(req_aluctrl), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_aluout(rsp_aluout), .rsp_eq(rsp_eq),
        .alu_aluop1(alu_aluop1), .alu_aluop2(alu_aluop2),
        .alu_aluctrl(alu_aluctrl), .alu_funct3(alu_funct3),
        .alu_aluout(alu_aluout), .alu_eq(alu_eq)
    );

    // Stand-in ALU; unknown codes yield zero.
    always_comb begin
        case (alu_aluctrl)
            4'd0:    alu_aluout = alu_aluop1 + alu_aluop2;
            4'd1:    alu_aluout = alu_aluop1 - alu_aluop2;
            4'd2:    alu_aluout = alu_aluop1 & alu_aluop2;
            4'd3:    alu_aluout = alu_aluop1 | alu_aluop2;
            4'd4:    alu_aluout = alu_aluop1 ^ alu_aluop2;
            4'd5:    alu_aluout = alu_aluop1 << alu_aluop2[4:0];
            4'd6:    alu_aluout = alu_aluop1 >> alu_aluop2[4:0];
            4'd7:    alu_aluout = $signed(alu_aluop1) >>> alu_aluop2[4:0];
            4'd8:    alu_aluout = {31'd0, $signed(alu_aluop1) < $signed(alu_aluop2)};
            4'd9:    alu_aluout = {31'd0, alu_aluop1 < alu_aluop2};
            default: alu_aluout = '0;
        endcase
        case (alu_funct3)
            3'b000:  alu_eq = (alu_aluop1 == alu_aluop2);
            3'b001:  alu_eq = (alu_aluop1 != alu_aluop2);
            3'b100:  alu_eq = ($signed(alu_aluop1) <  $signed(alu_aluop2));
            3'b101:  alu_eq = ($signed(alu_aluop1) >= $signed(alu_aluop2));
            3'b110:  alu_eq = (alu_aluop1 <  alu_aluop2);
            3'b111:  alu_eq = (alu_aluop1 >= alu_aluop2);
            default: alu_eq = 1'b0;
        endcase
    end

    typedef struct {
        logic          id;
        logic [DW-1:0] op1, op2;
        logic [3:0]    ctrl;
        logic [2:0]    f3;
        logic [DW-1:0] out;
        logic          eq;
    } op_t;

    op_t pend0[$], pend1[$], sb[$];
    op_t last;
    int  grants[$];
    int  n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0;
    bit  exec_chk = 0, rsp_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic present(input int i);
        op_t o;
        if (i == 0 && pend0.size() > 0) o = pend0[0];
        else if (i == 1 && pend1.size() > 0) o = pend1[0];
        else begin
            req_valid[i] = 1'b0;
            return;
        end
        req_op1[i*DW +: DW]   = o.op1;
        req_op2[i*DW +: DW]   = o.op2;
        req_aluctrl[i*4 +: 4] = o.ctrl;
        req_funct3[i*3 +: 3]  = o.f3;
        req_valid[i]          = 1'b1;
    endtask

    task automatic add_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [3:0] c, input logic [2:0] f,
                          input logic [DW-1:0] out, input logic eq);
        op_t o;
        o.id = (i != 0); o.op1 = a; o.op2 = b; o.ctrl = c; o.f3 = f; o.out = out; o.eq = eq;
        if (i == 0) begin
            pend0.push_back(o);
            if (pend0.size() == 1) present(0);
        end else begin
            pend1.push_back(o);
            if (pend1.size() == 1) present(1);
        end
    endtask

    // One clock: sample at negedge, update requester drive just after posedge.
    task automatic step();
        logic g;
        bit   acc;
        op_t  e;
        acc = 0;
        g   = 1'b0;
        @(negedge clk);
        cyc++;
        if (exec_chk) begin
            chk("exec_op1", alu_aluop1, last.op1);
            chk("exec_op2", alu_aluop2, last.op2);
            chk("exec_ctrl", {28'd0, alu_aluctrl}, {28'd0, last.ctrl});
            chk("exec_f3", {29'd0, alu_funct3}, {29'd0, last.f3});
            chk("no_accept_in_exec", {30'd0, req_ready}, 32'd0);
            exec_chk = 0;
        end
        chk("ready_onehot", {31'd0, req_ready == 2'b11}, 32'd0);
        if (rsp_valid != 2'b00) begin
            chk("no_accept_in_resp", {30'd0, req_ready}, 32'd0);
            if (sb.size() == 0) chk("spurious_rsp", {30'd0, rsp_valid}, 32'd0);
            else begin
                e = sb[0];
                chk("rsp_valid", {30'd0, rsp_valid}, e.id ? 32'd2 : 32'd1);
                chk("rsp_aluout", rsp_aluout, e.out);
                chk("rsp_eq", {31'd0, rsp_eq}, {31'd0, e.eq});
                if (!rsp_seen) begin
                    chk("rsp_latency", cyc - acc_cyc, 32'd2);
                    rsp_seen = 1;
                end
                if (rsp_ready[e.id]) begin
                    sb.delete(0);
                    rsp_seen = 0;
                end
            end
        end
        if (|(req_valid & req_ready)) begin
            g = req_ready[1];
            e = g ? pend1[0] : pend0[0];
            sb.push_back(e);
            grants.push_back(int'(g));
            last     = e;
            acc_cyc  = cyc;
            exec_chk = 1;
            acc      = 1;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            if (g) pend1.delete(0); else pend0.delete(0);
            present(int'(g));
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((pend0.size() + pend1.size() + sb.size()) != 0 && n < max) begin
            step();
            n++;
        end
        chk("drain_timeout", pend0.size() + pend1.size() + sb.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_aluout"}, rsp_aluout, 32'd0);
        chk({tag, "_rsp_eq"}, {31'd0, rsp_eq}, 32'd0);
        chk({tag, "_aluop1"}, alu_aluop1, 32'd0);
        chk({tag, "_aluop2"}, alu_aluop2, 32'd0);
        chk({tag, "_aluctrl"}, {28'd0, alu_aluctrl}, 32'd0);
        chk({tag, "_funct3"}, {29'd0, alu_funct3}, 32'd0);
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        pend0.delete(); pend1.delete(); sb.delete(); grants.delete();
        exec_chk = 0;
        rsp_seen = 0;
        #1;
    endtask

    task automatic leave_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        req_valid = '0; req_op1 = '0; req_op2 = '0; req_aluctrl = '0; req_funct3 = '0;
        rsp_ready = 2'b11;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        leave_reset();

        // Single op: 5 + 7, beq false.
        add_op(0, 32'd5, 32'd7, 4'd0, 3'b000, 32'd12, 1'b0);
        drain(20);
        chk("single_ngrant", grants.size(), 32'd1);
        chk("single_grant", grants[0], 32'd0);

        // Both valid at reset release: sub 10-3, then slt -1 < 1.
        enter_reset();
        check_reset_outputs("rst1");
        add_op(0, 32'd10, 32'd3, 4'd1, 3'b000, 32'd7, 1'b0);
        add_op(1, 32'hFFFF_FFFF, 32'd1, 4'd8, 3'b000, 32'd1, 1'b0);
        leave_reset();
        drain(30);
        chk("simul_ngrant", grants.size(), 32'd2);
        chk("simul_first", grants[0], 32'd0);
        chk("simul_second", grants[1], 32'd1);

        // Fairness: both continuously valid for 8 operations.
        grants.delete();
        for (int k = 0; k < 4; k++) begin
            add_op(0, 32'h1000 + k, 32'(3*k), 4'd0, 3'b001, 32'h1000 + 32'(4*k), 1'b1);
            add_op(1, 32'h2000 + k, 32'(3*k), 4'd1, 3'b000, 32'h2000 - 32'(2*k), 1'b0);
        end
        drain(100);
        chk("fair_ngrant", grants.size(), 32'd8);
        for (int i = 0; i < 8; i++) chk("fair_grant", grants[i], 32'(i % 2));

        // Backpressure: owner 1 stalls four RESP cycles; requester 0 waits meanwhile.
        grants.delete();
        rsp_ready = 2'b01;
        add_op(1, 32'd1, 32'hFFFF_FFFF, 4'd0, 3'b110, 32'd0, 1'b1);
        for (int n = 0; n < 10 && grants.size() == 0; n++) step();
        add_op(0, 32'h0000_F0F0, 32'h0000_0FF0, 4'd4, 3'b100, 32'h0000_FF00, 1'b0);
        repeat (5) step();
        chk("bp_hold_valid", {30'd0, rsp_valid}, 32'd2);
        chk("bp_hold_eq", {31'd0, rsp_eq}, 32'd1);
        chk("bp_ngrant", grants.size(), 32'd1);
        rsp_ready = 2'b11;
        drain(30);
        chk("bp_order0", grants[0], 32'd1);
        chk("bp_order1", grants[1], 32'd0);

        // Signed bge false, and undefined codes passed straight through.
        grants.delete();
        add_op(0, 32'hFFFF_FFFE, 32'd1, 4'd8, 3'b101, 32'd1, 1'b0);
        drain(20);
        add_op(1, 32'd5, 32'd5, 4'hF, 3'b010, 32'd0, 1'b0);
        drain(20);

        // Reset during EXEC discards the op; pri restarts at 0 afterwards.
        grants.delete();
        add_op(0, 32'd3, 32'd4, 4'd0, 3'b000, 32'd7, 1'b0);
        for (int n = 0; n < 10 && grants.size() == 0; n++) step();
        chk("midop_accept", grants.size(), 32'd1);
        enter_reset();
        check_reset_outputs("rst_mid");
        leave_reset();
        repeat (3) begin
            step();
            chk("no_rsp_after_rst", {30'd0, rsp_valid}, 32'd0);
        end
        add_op(1, 32'd1, 32'd4, 4'd5, 3'b111, 32'd16, 1'b0);
        add_op(0, 32'hFFFF_FFFE, 32'd1, 4'd9, 3'b001, 32'd0, 1'b1);
        drain(30);
        chk("post_rst_ngrant", grants.size(), 32'd2);
        chk("post_rst_first", grants[0], 32'd0);
        chk("post_rst_second", grants[1], 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared integer ALU (add/sub/logic/shift/compare via `aluctrl`, branch condition via `funct3`). It sits between the ALU and its two clients, for example the execute stage and a branch/address helper. It accepts operations over valid/ready handshakes, grants the ALU round-robin, and registers operands for one execute cycle. It returns `aluout`/`eq` to the owning requester on a held response handshake. At most one operation is in flight.

## Interface
- `D_WIDTH`, 32, datapath width; must match the ALU.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  2  bit i = requester i has an operation pending.
- `req_ready`  out  2  bit i = operation of requester i accepted this cycle; at most one bit set.
- `req_op1`  in  2*D_WIDTH  slice i = operand 1 of requester i.
- `req_op2`  in  2*D_WIDTH  slice i = operand 2 of requester i.
- `req_aluctrl`  in  8  slice i = 4-bit ALU operation code of requester i.
- `req_funct3`  in  6  slice i = 3-bit branch-compare select of requester i.
- `rsp_valid`  out  2  bit i = result for requester i available; at most one bit set.
- `rsp_ready`  in  2  bit i = requester i consumes its result.
- `rsp_aluout`  out  D_WIDTH  registered ALU result, shared by both requesters.
- `rsp_eq`  out  1  registered branch-condition result, shared.
- `alu_aluop1`, `alu_aluop2`  out  D_WIDTH each  ALU operands, driven from internal registers.
- `alu_aluctrl`  out  4  ALU operation code, registered.
- `alu_funct3`  out  3  ALU compare select, registered.
- `alu_aluout`  in  D_WIDTH  ALU combinational result.
- `alu_eq`  in  1  ALU combinational compare result.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Priority pointer `pri` is 1 bit. Reset value is 0.
- Grant in IDLE:
  - If both `req_valid` bits are set, grant requester `pri`.
  - If only one bit is set, grant that requester.
  - `req_ready[g]` is a combinational function of state, `req_valid`, and `pri` only. It is 0 outside IDLE.
- On accept (IDLE, `req_valid[g] & req_ready[g]`):
  - Latch that requester's `op1`/`op2`/`aluctrl`/`funct3` into the ALU drive registers.
  - Latch owner id `g`.
  - Set `pri <= ~g`.
  - Go to EXEC.
- EXEC lasts one cycle. The ALU sees the registered operands. At the clock edge:
  - `rsp_aluout <= alu_aluout`
  - `rsp_eq <= alu_eq`
  - Go to RESP.
- RESP:
  - `rsp_valid[owner] = 1`; the other bit is 0.
  - `rsp_aluout`/`rsp_eq` stay stable until `rsp_ready[owner]` is sampled high.
  - On that handshake, go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- Requesters must hold `req_valid` and request data stable until accepted. A request that is not granted stays pending; it is never dropped.
- ALU drive registers hold their last values outside EXEC. The block does not interpret `aluctrl` or `funct3`; they pass through to the ALU, including undefined codes.
- Width rules:
  - Slice i of `req_op1`/`req_op2` = bits [i*D_WIDTH +: D_WIDTH].
  - Slice i of `req_aluctrl` = [i*4 +: 4].
  - Slice i of `req_funct3` = [i*3 +: 3].

## Timing
- Accept at edge T, EXEC during cycle T+1, `rsp_valid` high from cycle T+2.
- Minimum spacing between accepts is 3 cycles, assuming `rsp_ready` is high on the first RESP cycle.
- IDLE is always visited for at least one cycle after RESP. There is no accept during RESP.
- Reset values: `req_ready` 0, `rsp_valid` 0, `rsp_aluout` 0, `rsp_eq` 0, `alu_aluop1`/`alu_aluop2` 0, `alu_aluctrl` 0, `alu_funct3` 0, `pri` 0, state IDLE.
- Reset asserted mid-operation (EXEC or RESP):
  - All registers clear immediately and asynchronously.
  - The in-flight operation is discarded and no response is issued.
  - Requesters re-present their requests after reset.
- Both requesters valid continuously: grants alternate 0,1,0,1…
- Single requester valid with `pri` pointing at the idle requester: that requester is still granted in the same cycle (no bubble).
- `rsp_ready` held low: the block stays in RESP indefinitely. `req_ready` stays 0 for both requesters.

## Test plan
- Single op, idle:
  - Stimulus: after reset, requester 0 sends `aluctrl=0000`, `op1=5`, `op2=7`, `funct3=000`, `rsp_ready` high.
  - Response: `req_ready[0]` high in cycle T, `rsp_valid=2'b01` at T+2, `rsp_aluout=12`, `rsp_eq=0`, IDLE at T+3.
- Simultaneous requests:
  - Stimulus: both valid at reset release; req0 `sub` 10−3, req1 `slt` op1=0xFFFFFFFF, op2=1.
  - Response: req0 granted first with result 7; req1 granted next with result 1.
- Fairness:
  - Stimulus: both requesters valid for 8 operations.
  - Response: grant sequence 0,1,0,1,0,1,0,1; `req_ready` never `2'b11`.
- Backpressure:
  - Stimulus: req1 `bltu` `funct3=110`, op1=1, op2=0xFFFFFFFF; `rsp_ready[1]` low for 4 cycles; req0 valid meanwhile.
  - Response: `rsp_valid[1]` and `rsp_eq=1` stable for 5 cycles; `req_ready[0]` stays 0 until IDLE.
- Signed branch:
  - Stimulus: `funct3=101`, op1=0xFFFFFFFE, op2=1.
  - Response: `rsp_eq=0`.
- Reset mid-op:
  - Stimulus: drive `rst_n` low during EXEC.
  - Response: all outputs 0 within the same cycle, no `rsp_valid` after release; a re-presented request completes normally with `pri` restarted at 0.
